// File: rtl/scan_capture_spi.sv
// Purpose: captures an SC_CELL_V3 scan chain in parallel, shifts it out through SO and packs the bits into SRAM bytes.
// Latency: 4P + N + 4P(N-1) + ceil(N/8) CLK cycles from start to DONE (N = BIT_LEN+1, P = FREQ_DIV+1).
// Backpressure: none; the SRAM takes one write per WRITE cycle and BGN is only sampled in IDLE and DONE.
module scan_capture_spi #(
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int DIV_WIDTH      = 8
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      BGN,
    input  logic [MEM_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [LEN_WIDTH-1:0]      BIT_LEN,
    input  logic [DIV_WIDTH-1:0]      FREQ_DIV,
    input  logic                      SPI_SI,
    output logic                      SCLK1,
    output logic                      SCLK2,
    output logic                      SEL,
    output logic                      CEN,
    output logic                      WEN,
    output logic [MEM_ADDR_WIDTH-1:0] A,
    output logic [MEM_DATA_WIDTH-1:0] D,
    output logic                      busy,
    output logic                      spi_is_done
);

    // Width of the within-byte bit index (data width is a power of two, at least 2).
    localparam int BW = $clog2(MEM_DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_SAMPLE,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state;
    logic [1:0]                phase;        // 0: SCLK1 high, 1: gap, 2: SCLK2 high, 3: gap
    logic [DIV_WIDTH-1:0]      ph_cnt;       // cycles left in the current phase
    logic [DIV_WIDTH-1:0]      div_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      bit_cnt;      // index of the bit sampled next
    logic [BW-1:0]             bit_in_byte;  // bits already packed into byte_reg
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [MEM_DATA_WIDTH-1:0] byte_reg;
    logic                      last_q;       // the byte being written holds the final bit

    logic [MEM_DATA_WIDTH-1:0] new_byte;
    logic [MEM_DATA_WIDTH-1:0] aligned;
    logic [BW-1:0]             shamt;
    logic                      byte_full;
    logic                      last_bit;

    // Next packed byte and its right-aligned form; the first bit shifted in lands in bit 0
    // once the byte is full, so a partial byte is shifted down by the number of empty slots.
    always_comb begin
        new_byte  = {SPI_SI, byte_reg[MEM_DATA_WIDTH-1:1]};
        shamt     = BW'(MEM_DATA_WIDTH - 1) - bit_in_byte;
        aligned   = new_byte >> shamt;
        byte_full = (bit_in_byte == BW'(MEM_DATA_WIDTH - 1));
        last_bit  = (bit_cnt == len_q);
    end

    // Scan sequencer: phase timing, bit packing and SRAM write strobes, all outputs registered.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            phase       <= 2'd0;
            ph_cnt      <= '0;
            div_q       <= '0;
            len_q       <= '0;
            bit_cnt     <= '0;
            bit_in_byte <= '0;
            addr_q      <= '0;
            byte_reg    <= '0;
            last_q      <= 1'b0;
            SCLK1       <= 1'b0;
            SCLK2       <= 1'b0;
            SEL         <= 1'b0;
            CEN         <= 1'b1;
            WEN         <= 1'b1;
            A           <= '0;
            D           <= '0;
            busy        <= 1'b0;
            spi_is_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (BGN) begin
                        // Configuration is frozen here for the whole transfer.
                        div_q       <= FREQ_DIV;
                        len_q       <= BIT_LEN;
                        addr_q      <= ADDR_BGN;
                        ph_cnt      <= FREQ_DIV;
                        phase       <= 2'd0;
                        bit_cnt     <= '0;
                        bit_in_byte <= '0;
                        byte_reg    <= '0;
                        last_q      <= 1'b0;
                        SCLK1       <= 1'b1;
                        SEL         <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_CAPT;
                    end
                end

                // Capture and shift share the same four-phase clock sequence;
                // only SEL differs, and SEL is already low on entry to SHIFT.
                S_CAPT, S_SHIFT: begin
                    if (ph_cnt != '0) begin
                        ph_cnt <= ph_cnt - DIV_WIDTH'(1);
                    end else begin
                        ph_cnt <= div_q;
                        phase  <= phase + 2'd1;
                        case (phase)
                            2'd0: SCLK1 <= 1'b0;
                            2'd1: SCLK2 <= 1'b1;
                            2'd2: SCLK2 <= 1'b0;
                            2'd3: begin
                                SEL   <= 1'b0;
                                state <= S_SAMPLE;
                            end
                        endcase
                    end
                end

                S_SAMPLE: begin
                    byte_reg    <= new_byte;
                    bit_cnt     <= bit_cnt + LEN_WIDTH'(1);
                    bit_in_byte <= bit_in_byte + BW'(1);
                    last_q      <= last_bit;
                    if (byte_full || last_bit) begin
                        CEN   <= 1'b0;
                        WEN   <= 1'b0;
                        A     <= addr_q;
                        D     <= aligned;
                        state <= S_WRITE;
                    end else begin
                        SCLK1  <= 1'b1;
                        ph_cnt <= div_q;
                        phase  <= 2'd0;
                        state  <= S_SHIFT;
                    end
                end

                S_WRITE: begin
                    // Address wraps naturally at the top of the SRAM.
                    CEN         <= 1'b1;
                    WEN         <= 1'b1;
                    addr_q      <= addr_q + MEM_ADDR_WIDTH'(1);
                    byte_reg    <= '0;
                    bit_in_byte <= '0;
                    if (last_q) begin
                        busy        <= 1'b0;
                        spi_is_done <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        SCLK1  <= 1'b1;
                        ph_cnt <= div_q;
                        phase  <= 2'd0;
                        state  <= S_SHIFT;
                    end
                end

                S_DONE: begin
                    // A level-held BGN must be released before another run can start.
                    if (!BGN) begin
                        spi_is_done <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_capture_spi.sv
// Purpose: scoreboard bench for scan_capture_spi with a two-phase scan chain model behind SPI_SI.
// Latency: expected SRAM writes are queued per run and matched in order by the write monitor.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_scan_capture_spi;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       BGN;
    logic [8:0] ADDR_BGN;
    logic [7:0] BIT_LEN;
    logic [7:0] FREQ_DIV;
    logic       SPI_SI;
    logic       SCLK1, SCLK2, SEL, CEN, WEN;
    logic [8:0] A;
    logic [7:0] D;
    logic       busy, spi_is_done;

    scan_capture_spi #(
        .MEM_ADDR_WIDTH(9),
        .MEM_DATA_WIDTH(8),
        .LEN_WIDTH(8),
        .DIV_WIDTH(8)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .BGN(BGN), .ADDR_BGN(ADDR_BGN), .BIT_LEN(BIT_LEN),
        .FREQ_DIV(FREQ_DIV), .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2), .SEL(SEL),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .busy(busy), .spi_is_done(spi_is_done)
    );

    always #5 CLK = ~CLK;

    localparam logic [23:0] RST_VAL = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 1'b0};

    int n_chk = 0;
    int n_pass = 0;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int wr_cnt = 0, busy_cyc = 0, sel_cyc = 0, overlap = 0, pulse_bad = 0, caps = 0;
    int exp_p = 1, w1 = 0, w2 = 0;
    logic sel_prev = 1'b0;

    // Scan chain model: master latches on SCLK1, slave on SCLK2, bit 0 drives SO.
    logic [15:0] pin_v = '0;
    logic [15:0] master = '0;
    logic [15:0] slave = '0;
    assign SPI_SI = slave[0];
    always @(negedge SCLK1) master = SEL ? pin_v : (slave >> 1);
    always @(negedge SCLK2) slave = master;

    function automatic logic [23:0] outs();
        return {SCLK1, SCLK2, SEL, CEN, WEN, A, D, busy, spi_is_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: clock shape, SEL/busy accounting and in-order SRAM write scoreboard.
    always @(negedge CLK) begin
        if (!rst_n) begin
            w1 = 0;
            w2 = 0;
            sel_prev = 1'b0;
        end else begin
            if (SCLK1 && SCLK2) overlap++;
            if (busy) busy_cyc++;
            if (SEL) sel_cyc++;
            if (SEL && !sel_prev) caps++;
            sel_prev = SEL;
            if (SCLK1) w1++;
            else if (w1 != 0) begin
                if (w1 != exp_p) pulse_bad++;
                w1 = 0;
            end
            if (SCLK2) w2++;
            else if (w2 != 0) begin
                if (w2 != exp_p) pulse_bad++;
                w2 = 0;
            end
            if (!CEN && !WEN) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: A=%0h D=%0h, required no write", A, D);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(A), 32'(e[16:8]));
                    chk("wr_data", 32'(D), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic run(input logic [15:0] pat, input logic [8:0] addr, input logic [7:0] len,
                       input logic [7:0] div, input int exp_cyc, input int exp_wr, input bit hold);
        int  wr0;
        bit  seen;
        pin_v    = pat;
        ADDR_BGN = addr;
        BIT_LEN  = len;
        FREQ_DIV = div;
        exp_p    = int'(div) + 1;
        @(negedge CLK);
        busy_cyc  = 0;
        sel_cyc   = 0;
        overlap   = 0;
        pulse_bad = 0;
        wr0       = wr_cnt;
        BGN       = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge CLK);
            if (spi_is_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!hold) BGN = 1'b0;
        chk("cycles", busy_cyc, exp_cyc);
        chk("writes", wr_cnt - wr0, exp_wr);
        chk("queue_empty", exp_q.size(), 0);
        chk("overlap", overlap, 0);
        chk("pulse_width", pulse_bad, 0);
        chk("sel_cycles", sel_cyc, 4 * (int'(div) + 1));
    endtask

    initial begin
        int  wr0;
        int  caps0;
        bit  seen;
        rst_n = 1'b0;
        BGN = 1'b0;
        ADDR_BGN = '0;
        BIT_LEN = '0;
        FREQ_DIV = '0;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", 32'(outs()), 32'(RST_VAL));
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // 14-bit chain, full speed: 4 + 14 + 52 + 2 = 72 cycles.
        exp_q.push_back({9'h000, 8'h5C});
        exp_q.push_back({9'h001, 8'h2A});
        run(16'h2A5C, 9'h000, 8'd13, 8'd0, 72, 2, 1'b0);

        // Same chain, 4-cycle phases: 16 + 14 + 208 + 2 = 240 cycles.
        exp_q.push_back({9'h000, 8'h5C});
        exp_q.push_back({9'h001, 8'h2A});
        run(16'h2A5C, 9'h000, 8'd13, 8'd3, 240, 2, 1'b0);

        // 16 bits starting at the top address: wraps to 0. 4 + 16 + 60 + 2 = 82.
        exp_q.push_back({9'h1FF, 8'hEF});
        exp_q.push_back({9'h000, 8'hBE});
        run(16'hBEEF, 9'h1FF, 8'd15, 8'd0, 82, 2, 1'b0);

        // Single-bit chain: one write of 8'h01. 4 + 1 + 0 + 1 = 6.
        exp_q.push_back({9'h055, 8'h01});
        run(16'h0001, 9'h055, 8'd0, 8'd0, 6, 1, 1'b0);

        // Reset in the middle of the second byte's shifting.
        pin_v = 16'h2A5C;
        ADDR_BGN = 9'h010;
        BIT_LEN = 8'd13;
        FREQ_DIV = 8'd1;
        exp_p = 2;
        exp_q.push_back({9'h010, 8'h5C});
        exp_q.push_back({9'h011, 8'h2A});
        @(negedge CLK);
        wr0 = wr_cnt;
        BGN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CLK);
            if (wr_cnt != wr0) seen = 1'b1;
        end
        chk("abort_first_write", wr_cnt - wr0, 1);
        repeat (3) @(negedge CLK);
        BGN = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", 32'(outs()), 32'(RST_VAL));
        exp_q.delete();
        wr0 = wr_cnt;
        repeat (5) @(negedge CLK);
        rst_n = 1'b1;
        repeat (20) @(negedge CLK);
        chk("abort_no_writes", wr_cnt - wr0, 0);
        chk("abort_idle", 32'(busy), 32'd0);
        // Clean restart: 8 + 14 + 104 + 2 = 128 cycles.
        exp_q.push_back({9'h010, 8'h5C});
        exp_q.push_back({9'h011, 8'h2A});
        run(16'h2A5C, 9'h010, 8'd13, 8'd1, 128, 2, 1'b0);

        // BGN held through DONE must not retrigger.
        exp_q.push_back({9'h020, 8'h01});
        run(16'h0001, 9'h020, 8'd0, 8'd0, 6, 1, 1'b1);
        caps0 = caps;
        repeat (20) @(negedge CLK);
        chk("hold_done", 32'(spi_is_done), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_no_recapture", caps - caps0, 0);
        BGN = 1'b0;
        @(posedge CLK);
        #1 chk("done_drop", 32'(spi_is_done), 32'd0);
        repeat (5) @(negedge CLK);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("no_capture_after_done", caps - caps0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
